serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit ripple subtractor, the inverse datapath of the team's ripple adder: given the adder's `sum` and one of its operands, it recovers the other operand. It processes one bit per clock, LSB first, through a single full-subtractor cell. A start/busy/done handshake lets a controller or testbench issue operations and collect registered results. It sits beside the adder in the arithmetic test datapath and trades latency for area.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only while `busy`=0 and `done`=0
- a  input  WIDTH  minuend, sampled on the accepting edge
- b  input  WIDTH  subtrahend, sampled on the accepting edge
- bin  input  1  borrow-in, sampled on the accepting edge
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse when results become valid
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH, registered
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned), registered

## Operation
- FSM states:
  - IDLE: waits for `start`. `start`=1 at a clock edge latches a, b, bin into internal shift registers, clears the bit counter and moves to RUN.
  - RUN: each edge feeds operand LSBs and the running borrow into the full-subtractor cell, shifts the difference bit into the result shift register from the MSB side, shifts the operands right and increments the counter. After the WIDTH-th RUN edge, the state moves to DONE.
  - DONE: `diff` and `bout` load on the edge entering DONE; `done`=1 for exactly one cycle; the next edge returns to IDLE.
- Full-subtractor cell: d = a⊕b⊕bi; bo = (¬a∧b) ∨ (¬(a⊕b)∧bi).
- `start` is ignored in RUN and DONE; there is no queueing.
- Changes on a, b, bin after acceptance have no effect on the operation in flight.
- `diff`/`bout` hold their last result until the next completion; they never show partial values.
- rst at any time, including mid-RUN, immediately forces IDLE. The partial result is discarded.
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, counter=0, internal shift registers=0.

## Timing
- Accept edge E0 (IDLE, `start`=1): `busy` rises after E0.
- RUN edges E1..EWIDTH compute bits 0..WIDTH−1. `busy` falls and `done`, `diff`, `bout` update after EWIDTH.
- `done` falls after E(WIDTH+1), back in IDLE.
- Latency is WIDTH edges from accept to valid result. With `start` held high, throughput is one operation per WIDTH+2 cycles; the next accept is E(WIDTH+2).
- Reset deasserted asynchronously with respect to clk: the first edge after release is treated as an IDLE edge.

## Structure
- Shared package `sub_pkg`:
  - state enum {IDLE, RUN, DONE}
  - default width constant 8
  - counter width = $clog2(WIDTH+1)
- Sub-module `full_subtractor_bit`: combinational 1-bit cell (a, b, bi → d, bo), instantiated once.
- The top module holds the FSM, counter, operand/result shift registers and output registers.

## Test plan
- Reset mid-operation: accept 0x55−0x0F, assert rst after 3 RUN edges → `busy`=0, `done`=0, `diff`=0x00, `bout`=0 immediately. A fresh 0x10−0x01 then yields 0x0F.
- Inverse of adder: a=0xFF, b=0xAA, bin=0 → `diff`=0x55, `bout`=0, `done` pulse exactly 8 edges after accept.
- Wrap-around: a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1.
- Borrow-in: a=0xFF, b=0xFF, bin=1 → `diff`=0xFF, `bout`=1. Also a=0x01, b=0x00, bin=1 → `diff`=0x00, `bout`=0.
- Input isolation: accept 0x3C−0x0C, then drive a=0xFF, b=0x00 and pulse `start` during RUN → result 0x30, `bout`=0, no second operation starts.
- Back-to-back: hold `start`=1 with a=0x80, b=0x01 → `done` pulses every 10 cycles, each with `diff`=0x7F and `bout`=0.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared types and constants for the bit-serial subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: combinational 1-bit full-subtractor cell
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with start/busy/done handshake
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br, d, bo;
  logic [CW-1:0]    cnt;
  full_subtractor_bit u_fs (
    .a (sa[0]),
    .b (sb[0]),
    .bi(br),
    .d (d),
    .bo(bo)
  );
  // FSM: latch operands, ripple one bit per RUN edge, publish result on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= bin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sr  <= {d, sr[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= {d, sr[WIDTH-1:1]};
            bout  <= bo;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed + randomized checks against an arithmetic reference model
module tb_serial_subtractor;
  localparam int W  = 8;
  localparam int W1 = W + 1;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  int           checks = 0, errors = 0, cyc = 0;
  bit           chk_en = 1'b0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );
  task automatic chkv(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // reference model: result from plain arithmetic, visible after W edges, done for one cycle
  logic         m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, p_bout = 1'b0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  int           m_left = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_diff <= p_diff;
        m_bout <= p_bout;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_left <= W;
      p_diff <= a - b - W'(bin);
      p_bout <= {1'b0, a} < ({1'b0, b} + W1'(bin));
    end
  end
  // compare process: every cycle, shortly after the active edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (chk_en && !rst) begin
      chk1("busy", busy, m_busy);
      chk1("done", done, m_done);
      chkv("diff", diff, m_diff);
      chk1("bout", bout, m_bout);
    end
  end
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       input logic [W-1:0] ed, input logic eb);
    int n = 0;
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    chki("latency", n, W);
    chkv("op_diff", diff, ed);
    chk1("op_bout", bout, eb);
    chkv("model_diff", m_diff, ed);
    chk1("model_bout", m_bout, eb);
    @(negedge clk);
    chk1("done_pulse_end", done, 1'b0);
  endtask
  initial begin
    int n;
    int q[$];
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkv("rst_diff", diff, 8'h00);
    chk1("rst_bout", bout, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    // reset in the middle of a run
    @(negedge clk);
    a = 8'h55; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk1("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chkv("mid_rst_diff", diff, 8'h00);
    chk1("mid_rst_bout", bout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    do_op(8'hFF, 8'hAA, 1'b0, 8'h55, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op(8'h01, 8'h00, 1'b1, 8'h00, 1'b0);
    // input isolation and start ignored during RUN
    @(negedge clk);
    a = 8'h3C; b = 8'h0C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    chki("iso_latency", n, W);
    chkv("iso_diff", diff, 8'h30);
    chk1("iso_bout", bout, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk1("iso_no_second", busy, 1'b0);
    end
    // back-to-back with start held high
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        q.push_back(cyc);
        chkv("b2b_diff", diff, 8'h7F);
        chk1("b2b_bout", bout, 1'b0);
      end
    end
    start = 1'b0;
    chki("b2b_pulses", q.size(), 4);
    for (int i = 1; i < q.size(); i++) chki("b2b_period", q[i] - q[i-1], W + 2);
    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      start = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
